// File: rtl/adc045_scan_ctrl.sv
// Multiplexed-ADC scan controller: on a sync edge, walks the enabled channels in
// ascending order, settles the analog mux, requests one conversion, and reports each result.
`timescale 1ns/1ps
module adc045_scan_ctrl #(
  parameter int N_CH        = 4,
  parameter int SETTLE_CYC  = 16,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                    clk,
  input  logic                    rst_l,
  input  logic                    sync,
  input  logic [N_CH-1:0]         ch_mask,
  input  logic                    sample_valid,
  input  logic [23:0]             sample_data,
  output logic [$clog2(N_CH)-1:0] a_mux,
  output logic                    conv_start,
  output logic                    res_valid,
  output logic [$clog2(N_CH)-1:0] res_ch,
  output logic [23:0]             res_data,
  output logic                    frame_done,
  output logic                    busy,
  output logic                    err_timeout,
  output logic                    err_overrun
);

  localparam int CH_W  = $clog2(N_CH);
  localparam int PTR_W = CH_W + 1;
  localparam int SET_W = $clog2(SETTLE_CYC + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYC);

  typedef enum logic [2:0] {IDLE, SETTLE, START, WAIT, NEXT, DONE} state_e;

  state_e            state_q, state_d;
  logic [N_CH-1:0]   mask_q, mask_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [CH_W-1:0]   mux_q, mux_d;
  logic [SET_W-1:0]  settle_q, settle_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              res_valid_q, res_valid_d;
  logic [CH_W-1:0]   res_ch_q, res_ch_d;
  logic [23:0]       res_data_q, res_data_d;
  logic              err_tmo_q, err_tmo_d;
  logic              err_ovr_q;
  logic              sync_q, armed_q;
  logic              sync_edge;
  logic              hit;
  logic [CH_W-1:0]   hit_ch;

  // armed_q blocks the first cycle after reset, so a sync held high through
  // reset release is never mistaken for a rising edge.
  assign sync_edge = armed_q & sync & ~sync_q;

  // Lowest enabled channel at or above the search pointer.
  always_comb begin
    hit    = 1'b0;
    hit_ch = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (mask_q[i] && (i >= int'(ptr_q))) begin
        hit    = 1'b1;
        hit_ch = CH_W'(i);
      end
    end
  end

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    state_d     = state_q;
    mask_d      = mask_q;
    ptr_d       = ptr_q;
    mux_d       = mux_q;
    settle_d    = settle_q;
    tmo_d       = tmo_q;
    res_valid_d = 1'b0;
    res_ch_d    = res_ch_q;
    res_data_d  = res_data_q;
    err_tmo_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sync_edge) begin
          mask_d  = ch_mask;
          ptr_d   = '0;
          state_d = NEXT;
        end
      end
      NEXT: begin
        if (hit) begin
          mux_d    = hit_ch;
          settle_d = '0;
          state_d  = SETTLE;
        end else begin
          state_d = DONE;
        end
      end
      SETTLE: begin
        // First SETTLE cycle is the mux switch itself; SETTLE_CYC stable cycles follow it.
        if (settle_q == SET_W'(SETTLE_CYC)) state_d = START;
        else                                settle_d = settle_q + SET_W'(1);
      end
      START: begin
        tmo_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (sample_valid) begin
          res_valid_d = 1'b1;
          res_ch_d    = mux_q;
          res_data_d  = sample_data;
          ptr_d       = {1'b0, mux_q} + PTR_W'(1);
          state_d     = NEXT;
        end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
          err_tmo_d = 1'b1;
          ptr_d     = {1'b0, mux_q} + PTR_W'(1);
          state_d   = NEXT;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: every register, including the result word, has an async reset so outputs are defined immediately.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q     <= IDLE;
      mask_q      <= '0;
      ptr_q       <= '0;
      mux_q       <= '0;
      settle_q    <= '0;
      tmo_q       <= '0;
      res_valid_q <= 1'b0;
      res_ch_q    <= '0;
      res_data_q  <= '0;
      err_tmo_q   <= 1'b0;
      err_ovr_q   <= 1'b0;
      sync_q      <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      mask_q      <= mask_d;
      ptr_q       <= ptr_d;
      mux_q       <= mux_d;
      settle_q    <= settle_d;
      tmo_q       <= tmo_d;
      res_valid_q <= res_valid_d;
      res_ch_q    <= res_ch_d;
      res_data_q  <= res_data_d;
      err_tmo_q   <= err_tmo_d;
      err_ovr_q   <= sync_edge & (state_q != IDLE);
      sync_q      <= sync;
      armed_q     <= 1'b1;
    end
  end

  assign a_mux       = mux_q;
  assign conv_start  = (state_q == START);
  assign res_valid   = res_valid_q;
  assign res_ch      = res_ch_q;
  assign res_data    = res_data_q;
  assign frame_done  = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign err_timeout = err_tmo_q;
  assign err_overrun = err_ovr_q;

endmodule

// File: tb/tb_adc045_scan_ctrl.sv
// Self-checking bench for adc045_scan_ctrl: a frame-timeline model predicts every
// output per cycle; directed frames add hand-computed literal checks.
`timescale 1ns/1ps
module tb_adc045_scan_ctrl;

  localparam int N_CH   = 4;
  localparam int SETTLE = 5;
  localparam int TMO    = 80;
  localparam int DEPTH  = 8192;
  localparam int WDOG   = 6000;

  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic        sync = 1'b0;
  logic [3:0]  ch_mask = '0;
  logic        sample_valid = 1'b0;
  logic [23:0] sample_data = '0;
  logic [1:0]  a_mux, res_ch;
  logic        conv_start, res_valid, frame_done, busy, err_timeout, err_overrun;
  logic [23:0] res_data;

  adc045_scan_ctrl #(.N_CH(N_CH), .SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_l(rst_l), .sync(sync), .ch_mask(ch_mask),
    .sample_valid(sample_valid), .sample_data(sample_data),
    .a_mux(a_mux), .conv_start(conv_start), .res_valid(res_valid), .res_ch(res_ch),
    .res_data(res_data), .frame_done(frame_done), .busy(busy),
    .err_timeout(err_timeout), .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected-event timeline, indexed by absolute cycle.
  bit          exp_busy[DEPTH];
  bit          ev_cs[DEPTH], ev_done[DEPTH], ev_tmo[DEPTH], ev_ovr[DEPTH];
  bit          ev_res_v[DEPTH], ev_amux_v[DEPTH];
  logic [1:0]  ev_res_ch[DEPTH], ev_amux[DEPTH];
  logic [23:0] ev_res_data[DEPTH];

  // Reader behaviour: reply delay per channel (0 = silent) and reply word.
  int          rd_dly[N_CH];
  logic [23:0] rd_data[N_CH];
  int          stray_cyc = -1;

  // Observed-event record for literal checks.
  int n_cs, first_cs, n_res, n_done, done_cyc, busy_cyc, n_tmo, tmo_cyc, n_ovr;
  int cs_ch[$];
  int res_chq[$];

  task automatic clear_mon();
    n_cs = 0; first_cs = -1; n_res = 0; n_done = 0; done_cyc = -1;
    busy_cyc = 0; n_tmo = 0; tmo_cyc = -1; n_ovr = 0;
    cs_ch.delete(); res_chq.delete();
  endtask

  // Frame timeline from the scan rules: NEXT, mux switch + SETTLE stable cycles,
  // one START, then either reply+1 or timeout+1 back to NEXT.
  task automatic plan_frame(input int t, input logic [3:0] mask, output int done);
    int cur, cs, d;
    cur = t + 1;
    for (int ch = 0; ch < N_CH; ch++) begin
      if (mask[ch]) begin
        ev_amux_v[cur+1] = 1'b1;
        ev_amux[cur+1]   = 2'(ch);
        cs = cur + SETTLE + 2;
        ev_cs[cs] = 1'b1;
        d = rd_dly[ch];
        if (d != 0 && d <= TMO) begin
          ev_res_v[cs+d+1]    = 1'b1;
          ev_res_ch[cs+d+1]   = 2'(ch);
          ev_res_data[cs+d+1] = rd_data[ch];
          cur = cs + d + 1;
        end else begin
          ev_tmo[cs+TMO+1] = 1'b1;
          cur = cs + TMO + 1;
        end
      end
    end
    done = cur + 1;
    ev_done[done] = 1'b1;
    for (int c = t + 1; c <= done; c++) exp_busy[c] = 1'b1;
  endtask

  task automatic model_reset(input int from);
    for (int c = from; c < DEPTH; c++) begin
      exp_busy[c] = 0; ev_cs[c] = 0; ev_done[c] = 0; ev_tmo[c] = 0; ev_ovr[c] = 0;
      ev_res_v[c] = 0; ev_amux_v[c] = 0;
    end
  endtask

  // One-cycle sync pulse; the model decides acceptance from its own busy timeline.
  task automatic pulse_sync(input logic [3:0] mask, output int t, output int done);
    @(negedge clk);
    ch_mask = mask;
    sync = 1'b1;
    t = cyc;
    if (exp_busy[t]) begin
      ev_ovr[t+1] = 1'b1;
      done = -1;
    end else begin
      plan_frame(t, mask, done);
    end
    @(negedge clk);
    sync = 1'b0;
  endtask

  task automatic run_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // ADC reader: answers conv_start after rd_dly cycles; can inject one stray pulse.
  initial begin
    int due;
    logic [1:0] cur_ch;
    due = -1;
    cur_ch = '0;
    forever begin
      @(negedge clk);
      if (!rst_l) begin
        due = -1;
        sample_valid = 1'b0;
      end else begin
        sample_valid = (cyc == due) || (cyc == stray_cyc);
        sample_data  = (cyc == due) ? rd_data[cur_ch] : 24'h5A5A5A;
        if (conv_start && rd_dly[a_mux] != 0) begin
          due = cyc + rd_dly[a_mux];
          cur_ch = a_mux;
        end
      end
    end
  end

  // Per-cycle compare against the timeline, plus event recording.
  initial begin
    logic [1:0]  m_amux, m_res_ch;
    logic [23:0] m_res_data;
    m_amux = '0; m_res_ch = '0; m_res_data = '0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (cyc > WDOG) begin
        $display("FAIL watchdog: cycle %0d exceeded limit %0d", cyc, WDOG);
        $fatal(1, "watchdog");
      end
      if (!rst_l) begin
        m_amux = '0; m_res_ch = '0; m_res_data = '0;
        check("reset_ctl", {a_mux, conv_start, res_valid, res_ch, frame_done, busy,
                            err_timeout, err_overrun}, '0);
        check("reset_res_data", res_data, '0);
      end else begin
        if (ev_amux_v[cyc]) m_amux = ev_amux[cyc];
        if (ev_res_v[cyc]) begin
          m_res_ch   = ev_res_ch[cyc];
          m_res_data = ev_res_data[cyc];
        end
        check("a_mux", a_mux, m_amux);
        check("conv_start", conv_start, ev_cs[cyc]);
        check("res_valid", res_valid, ev_res_v[cyc]);
        check("res_ch", res_ch, m_res_ch);
        check("res_data", res_data, m_res_data);
        check("frame_done", frame_done, ev_done[cyc]);
        check("busy", busy, exp_busy[cyc]);
        check("err_timeout", err_timeout, ev_tmo[cyc]);
        check("err_overrun", err_overrun, ev_ovr[cyc]);
        if (conv_start) begin
          n_cs++;
          cs_ch.push_back(int'(a_mux));
          if (first_cs < 0) first_cs = cyc;
        end
        if (res_valid) begin n_res++; res_chq.push_back(int'(res_ch)); end
        if (frame_done) begin n_done++; done_cyc = cyc; end
        if (busy) busy_cyc++;
        if (err_timeout) begin n_tmo++; tmo_cyc = cyc; end
        if (err_overrun) n_ovr++;
      end
    end
  end

  function automatic int at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  initial begin
    int t, done, t2, d2;
    clear_mon();
    for (int ch = 0; ch < N_CH; ch++) begin
      rd_dly[ch]  = 50;
      rd_data[ch] = 24'h000100 * ch;
    end

    repeat (3) @(negedge clk);
    check("por_busy", busy, 0);
    check("por_a_mux", a_mux, 0);
    rst_l = 1'b1;
    repeat (2) @(negedge clk);

    // Full mask, 50-cycle reader; ch_mask dropped mid-frame must not matter.
    clear_mon();
    pulse_sync(4'b1111, t, done);
    ch_mask = 4'b0000;
    run_until(done + 3);
    check("t1_first_cs_latency", first_cs - t, SETTLE + 3);
    check("t1_n_res", n_res, 4);
    for (int i = 0; i < 4; i++) check($sformatf("t1_res_ch%0d", i), at(res_chq, i), i);
    check("t1_n_done", n_done, 1);
    check("t1_done_offset", done_cyc - t, 234);

    // Stray sample in IDLE, then mask 1010 with a stray during SETTLE.
    for (int ch = 0; ch < N_CH; ch++) begin
      rd_dly[ch]  = 3;
      rd_data[ch] = 24'hF00000 | 24'(ch);
    end
    clear_mon();
    stray_cyc = cyc + 2;
    run_until(cyc + 5);
    check("t2_idle_stray_res", n_res, 0);
    stray_cyc = cyc + 1 + 4;
    pulse_sync(4'b1010, t, done);
    run_until(done + 3);
    check("t2_n_cs", n_cs, 2);
    check("t2_cs_mux0", at(cs_ch, 0), 1);
    check("t2_cs_mux1", at(cs_ch, 1), 3);
    check("t2_res_ch0", at(res_chq, 0), 1);
    check("t2_res_ch1", at(res_chq, 1), 3);
    check("t2_done_offset", done_cyc - t, 24);

    // Empty mask.
    clear_mon();
    pulse_sync(4'b0000, t, done);
    run_until(done + 3);
    check("t3_n_cs", n_cs, 0);
    check("t3_done_offset", done_cyc - t, 2);
    check("t3_busy_cycles", busy_cyc, 2);

    // Channel 0 silent -> timeout; channel 1 answers.
    rd_dly[0] = 0;
    rd_dly[1] = 7;
    clear_mon();
    pulse_sync(4'b0011, t, done);
    run_until(done + 3);
    check("t4_tmo_after_wait", tmo_cyc - (first_cs + 1), TMO);
    check("t4_n_tmo", n_tmo, 1);
    check("t4_n_res", n_res, 1);
    check("t4_res_ch", at(res_chq, 0), 1);

    // Reply on the last WAIT cycle: sample wins over timeout.
    rd_dly[0] = TMO;
    clear_mon();
    pulse_sync(4'b0001, t, done);
    run_until(done + 3);
    check("t5_n_tmo", n_tmo, 0);
    check("t5_n_res", n_res, 1);

    // Second sync mid-frame -> overrun only.
    for (int ch = 0; ch < N_CH; ch++) rd_dly[ch] = 10;
    clear_mon();
    pulse_sync(4'b0110, t, done);
    run_until(t + 20);
    pulse_sync(4'b1111, t2, d2);
    run_until(done + 6);
    check("t6_n_ovr", n_ovr, 1);
    check("t6_n_done", n_done, 1);
    check("t6_n_res", n_res, 2);
    check("t6_res_ch1", at(res_chq, 1), 2);

    // Reset during WAIT, sync held high across release, then a fresh frame.
    for (int ch = 0; ch < N_CH; ch++) rd_dly[ch] = 30;
    clear_mon();
    pulse_sync(4'b1111, t, done);
    run_until(t + 12);
    #2;
    rst_l = 1'b0;
    sync = 1'b1;
    model_reset(cyc + 1);
    #1;
    check("t7_rst_busy", busy, 0);
    check("t7_rst_res_ch", res_ch, 0);
    check("t7_rst_res_data", res_data, 0);
    repeat (3) @(negedge clk);
    rst_l = 1'b1;
    clear_mon();
    repeat (5) @(negedge clk);
    check("t7_held_sync_no_frame", busy_cyc, 0);
    check("t7_no_done", n_done, 0);
    sync = 1'b0;
    repeat (2) @(negedge clk);
    for (int ch = 0; ch < N_CH; ch++) rd_dly[ch] = 5;
    clear_mon();
    pulse_sync(4'b1111, t, done);
    run_until(done + 3);
    check("t7_n_res", n_res, 4);
    check("t7_n_done", n_done, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
